// File: rtl/ir_key_event_ctrl_pkg.sv
// Shared types and constants for the IR key-event controller: event codes,
// FSM state encoding, NEC frame field offsets and the event record layout.
package ir_ctrl_pkg;

  localparam int EVT_W = 18;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;
  localparam logic [1:0] EVT_RELEASE = 2'b11;

  localparam int F_ADDR_LSB = 0;
  localparam int F_CMD_LSB  = 16;
  localparam int F_CMDN_LSB = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_SWAP = 2'd2
  } ir_state_e;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] addr;
    logic [7:0] cmd;
  } ir_evt_t;

  // NEC integrity: the top byte must be the bitwise inverse of the command.
  function automatic logic frame_ok(input logic [31:0] d);
    return d[F_CMDN_LSB +: 8] == ~d[F_CMD_LSB +: 8];
  endfunction

endpackage

// File: rtl/ir_key_event_ctrl_if.sv
// Receiver-side frame inputs and consumer-side event handshake of the
// IR key-event controller; master = surrounding logic, slave = controller.
interface ir_key_event_ctrl_if #(parameter int CNT_W = 8) ();
  logic                         frame_valid;
  logic [31:0]                  frame_data;
  logic [7:0]                   cfg_addr;
  logic                         evt_valid;
  logic                         evt_ready;
  logic [ir_ctrl_pkg::EVT_W-1:0] evt_data;
  logic                         held;
  logic                         overflow;
  logic                         clr_overflow;
  logic [CNT_W-1:0]             drop_count;

  modport master (
    output frame_valid, frame_data, cfg_addr, evt_ready, clr_overflow,
    input  evt_valid, evt_data, held, overflow, drop_count
  );

  modport slave (
    input  frame_valid, frame_data, cfg_addr, evt_ready, clr_overflow,
    output evt_valid, evt_data, held, overflow, drop_count
  );
endinterface

// File: rtl/ir_key_event_ctrl_fifo.sv
// Small synchronous first-word-fall-through FIFO for key events.
// A push on a full FIFO is accepted only if a pop frees the slot that cycle.
module ir_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             wr_en, rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  // Head reads as zero when empty so the output bus has a defined idle value.
  assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
      if (rd_en) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ir_key_event_ctrl.sv
// Turns decoded NEC frames into PRESS/REPEAT/RELEASE key events with hold
// timeout, buffered in a FIFO. Optional macro IR_ADDR_FILTER_EN adds a device
// address filter against cfg_addr.
module ir_key_event_ctrl
  import ir_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 6000000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  ir_key_event_ctrl_if.slave bus
);
  localparam int TW = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

  ir_state_e        state_q;
  logic             fv_q;
  logic [TW-1:0]    timer_q;
  logic [15:0]      key_q;
  logic             overflow_q;
  logic [CNT_W-1:0] drop_q;

  logic        fstb, addr_ok, accept, same_key;
  logic [15:0] new_key;
  logic        push, pop, full, empty, drop;
  ir_evt_t     pevt;

  assign fstb    = bus.frame_valid & ~fv_q;
  assign new_key = {bus.frame_data[F_ADDR_LSB +: 8], bus.frame_data[F_CMD_LSB +: 8]};

`ifdef IR_ADDR_FILTER_EN
  assign addr_ok = (bus.frame_data[F_ADDR_LSB +: 8] == bus.cfg_addr);
  logic unused_fd;
  assign unused_fd = ^bus.frame_data[15:8];
`else
  assign addr_ok = 1'b1;
  logic unused_fd;
  assign unused_fd = ^{bus.frame_data[15:8], bus.cfg_addr};
`endif

  assign accept   = fstb & frame_ok(bus.frame_data) & addr_ok;
  assign same_key = (new_key == key_q);

  // Event to enqueue this cycle; written at the closing edge.
  always_comb begin
    push = 1'b0;
    pevt = '{typ: EVT_PRESS, addr: key_q[15:8], cmd: key_q[7:0]};
    case (state_q)
      S_IDLE: if (accept) begin
        push = 1'b1;
        pevt = '{typ: EVT_PRESS, addr: new_key[15:8], cmd: new_key[7:0]};
      end
      S_HELD: if (accept) begin
        push     = 1'b1;
        pevt.typ = same_key ? EVT_REPEAT : EVT_RELEASE;
      end else if (timer_q == '0) begin
        push     = 1'b1;
        pevt.typ = EVT_RELEASE;
      end
      S_SWAP: push = 1'b1;
      default: ;
    endcase
  end

  assign pop  = bus.evt_valid & bus.evt_ready;
  assign drop = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fv_q       <= 1'b0;
      timer_q    <= '0;
      key_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      fv_q <= bus.frame_valid;
      case (state_q)
        S_IDLE: if (accept) begin
          key_q   <= new_key;
          timer_q <= RELOAD;
          state_q <= S_HELD;
        end
        S_HELD: if (accept) begin
          timer_q <= RELOAD;
          if (!same_key) begin
            key_q   <= new_key;
            state_q <= S_SWAP;
          end
        end else if (timer_q == '0) begin
          state_q <= S_IDLE;
        end else begin
          timer_q <= timer_q - TW'(1);
        end
        // A frame in the one SWAP cycle is deliberately ignored.
        S_SWAP: state_q <= S_HELD;
        default: state_q <= S_IDLE;
      endcase
      if (bus.clr_overflow) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  ir_evt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EVT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pevt),
    .rdata (bus.evt_data),
    .full  (full),
    .empty (empty)
  );

  assign bus.evt_valid  = ~empty;
  assign bus.held       = (state_q == S_HELD);
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;

endmodule
